switch_debouncer: RTL and testbench

Synchronizes and debounces the eight raw ZedBoard slide switches before they reach the 4-bit ripple-carry adder. Each switch bit passes through a two-flop synchronizer and a per-bit stability counter. The block drives a clean, glitch-free `SWITCH` bus, whose nibbles are operands A and B of the adder. An optional one-cycle change strobe lets downstream logic detect operand updates.

---
 rtl/switch_debouncer.sv | 82 ++++++++
 tb/tb_switch_debouncer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// switch_debouncer
// Two-flop synchronizer plus a per-bit stability counter for the raw slide
// switches. The debounced SWITCH nibbles are the adder operands A and B.
// Optional feature macro: SWITCH_DEBOUNCER_CHANGED_EN. When it is defined,
// `changed` is a registered one-cycle strobe. When it is undefined, `changed`
// is tied to 0.
module switch_debouncer #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] SWITCH_RAW,
    output logic [WIDTH-1:0] SWITCH,
    output logic             changed
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    // Terminal count: the flip happens on the STABLE_CYCLES-th differing edge.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_switch;
    logic [CNT_W-1:0] r_cnt      [WIDTH];
    logic [CNT_W-1:0] w_cnt_next [WIDTH];
    logic [WIDTH-1:0] w_flip;

    // Per-bit decision: clear on agreement, flip at terminal count, else count up.
    always_comb begin
        w_flip = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_next[i] = '0;
            if (r_sync2[i] != r_switch[i]) begin
                if (r_cnt[i] == CNT_MAX) begin
                    w_flip[i] = 1'b1;
                end else begin
                    w_cnt_next[i] = r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Synchronizer, debounced outputs and counters. Reset clears every flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_switch <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1  <= SWITCH_RAW;
            r_sync2  <= r_sync1;
            r_switch <= r_switch ^ w_flip;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
        end
    end

    assign SWITCH = r_switch;

`ifdef SWITCH_DEBOUNCER_CHANGED_EN
    logic r_changed;

    // Strobe is registered on the same edge as the SWITCH update, so both become visible together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_changed <= 1'b0;
        end else begin
            r_changed <= |w_flip;
        end
    end

    assign changed = r_changed;
`else
    assign changed = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer
// Directed bench for switch_debouncer with STABLE_CYCLES=4 and WIDTH=8.
// The expected value of `changed` follows SWITCH_DEBOUNCER_CHANGED_EN.
module tb_switch_debouncer;

    localparam int W  = 8;
    localparam int SC = 4;
`ifdef SWITCH_DEBOUNCER_CHANGED_EN
    localparam logic CHG_EN = 1'b1;
`else
    localparam logic CHG_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic [W-1:0] raw;
    logic [W-1:0] sw;
    logic         chg;

    int n_checks = 0;
    int n_errors = 0;

    switch_debouncer #(
        .WIDTH        (W),
        .STABLE_CYCLES(SC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .SWITCH_RAW(raw),
        .SWITCH    (sw),
        .changed   (chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expectation and record the outcome.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a level and let the outputs settle.
    task automatic settle(input logic [W-1:0] v);
        raw = v;
        for (int i = 0; i < SC + 4; i++) tick();
        check_eq("settle", {24'd0, sw}, {24'd0, v});
    endtask

    logic [W-1:0] exp_sw;
    logic         exp_chg;
    logic [3:0]   sum;
    logic [6:0]   bounce;

    initial begin
        rst = 1'b1;
        raw = 8'hFF;

        // Reset held with all switches high
        for (int t = 1; t <= 3; t++) begin
            tick();
            check_eq("rst_sw", {24'd0, sw}, 32'h00);
            check_eq("rst_chg", {31'd0, chg}, 32'h0);
        end

        // Release: FF appears after the 6th edge
        rst = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            tick();
            exp_sw  = (t >= 6) ? 8'hFF : 8'h00;
            exp_chg = CHG_EN && (t == 6);
            check_eq("rel_sw", {24'd0, sw}, {24'd0, exp_sw});
            check_eq("rel_chg", {31'd0, chg}, {31'd0, exp_chg});
        end

        settle(8'h00);
        tick();
        tick();

        // Clean step to 8'h35
        raw = 8'h35;
        for (int t = 1; t <= 7; t++) begin
            tick();
            exp_sw  = (t >= 6) ? 8'h35 : 8'h00;
            exp_chg = CHG_EN && (t == 6);
            check_eq("step_sw", {24'd0, sw}, {24'd0, exp_sw});
            check_eq("step_chg", {31'd0, chg}, {31'd0, exp_chg});
        end
        sum = sw[3:0] + sw[7:4];
        check_eq("adder_sum", {28'd0, sum}, 32'h8);

        settle(8'h00);
        tick();
        tick();

        // Bounce rejection: 1,1,1,0,1,1,1 then low
        bounce = 7'b1110111;
        for (int t = 0; t < 15; t++) begin
            raw = (t < 7) ? {7'd0, bounce[6-t]} : 8'h00;
            tick();
            check_eq("bnc_sw", {24'd0, sw}, 32'h00);
            check_eq("bnc_chg", {31'd0, chg}, 32'h0);
        end

        // Bounce then settle high on bit 0
        for (int t = 0; t < 7; t++) begin
            raw = {7'd0, bounce[6-t]};
            tick();
            check_eq("bset_pre", {24'd0, sw}, 32'h00);
        end
        raw = 8'h00;
        tick();
        check_eq("bset_low", {24'd0, sw}, 32'h00);
        raw = 8'h01;
        for (int t = 1; t <= 7; t++) begin
            tick();
            exp_sw  = (t >= 6) ? 8'h01 : 8'h00;
            exp_chg = CHG_EN && (t == 6);
            check_eq("bset_sw", {24'd0, sw}, {24'd0, exp_sw});
            check_eq("bset_chg", {31'd0, chg}, {31'd0, exp_chg});
        end

        settle(8'h00);
        tick();
        tick();

        // Independent bits: bit 7 two cycles before bit 3
        raw = 8'h80;
        for (int t = 1; t <= 10; t++) begin
            if (t == 3) raw = 8'h88;
            tick();
            exp_sw  = (t >= 8) ? 8'h88 : (t >= 6) ? 8'h80 : 8'h00;
            exp_chg = CHG_EN && (t == 6 || t == 8);
            check_eq("ind_sw", {24'd0, sw}, {24'd0, exp_sw});
            check_eq("ind_chg", {31'd0, chg}, {31'd0, exp_chg});
        end

        settle(8'h00);
        tick();
        tick();

        // Reset mid-count on bit 2
        raw = 8'h04;
        for (int t = 1; t <= 3; t++) begin
            tick();
            check_eq("mid_pre", {24'd0, sw}, 32'h00);
        end
        rst = 1'b1;
        tick();
        check_eq("mid_rst", {24'd0, sw}, 32'h00);
        rst = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            tick();
            exp_sw  = (t >= 6) ? 8'h04 : 8'h00;
            exp_chg = CHG_EN && (t == 6);
            check_eq("mid_sw", {24'd0, sw}, {24'd0, exp_sw});
            check_eq("mid_chg", {31'd0, chg}, {31'd0, exp_chg});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
